udiv_scheduler: RTL

- Sequences one shared 32-bit UDivider instance between two requesters (port 0 and port 1).
- Treats the combinational divider as a multicycle path: registers the operands, waits WAIT_CYCLES clocks, then captures the quotient and remainder into a held response.
- Round-robin arbitration, valid/ready handshakes on both sides, divide-by-zero bypass.
- Sits between the ALU issue logic and the unsigned divider in the CPU arithmetic unit.

---
 rtl/udiv_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/udiv_scheduler.sv
// Round-robin scheduler sharing one combinational 32-bit unsigned divider between two requesters.
// Define UDIV_SCHED_STATS_EN to add per-port response counters (stat0_count, stat1_count).
module udiv_scheduler #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dividend,
  input  logic [31:0] req0_divisor,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dividend,
  input  logic [31:0] req1_divisor,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_quotient,
  output logic [31:0] resp_remainder,
  output logic        resp_divzero,
  output logic [1:0]  dbg_state
`ifdef UDIV_SCHED_STATS_EN
  ,
  output logic [15:0] stat0_count,
  output logic [15:0] stat1_count
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // ready never depends on the same port's operands, and a valid may be withdrawn before ready.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [31:0]      dividend_q, divisor_q;
  logic [CNT_W-1:0] cnt;
  logic             last, grant, accept;
  logic [31:0]      sel_dividend, sel_divisor;
  logic [31:0]      div_quotient, div_remainder;

  assign sel_dividend = grant ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant ? req1_divisor  : req0_divisor;

  // Divider sees only registered operands, so its output is a clean multicycle path.
  assign div_quotient  = dividend_q / divisor_q;
  assign div_remainder = dividend_q % divisor_q;

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    grant      = (req0_valid && req1_valid) ? ~last : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) state_next = (sel_divisor == '0) ? DONE : WAIT;
      end
      WAIT:    if (cnt == '0) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q     <= '0;
      divisor_q      <= '0;
      cnt            <= '0;
      last           <= 1'b1;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_divzero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dividend_q <= sel_dividend;
          divisor_q  <= sel_divisor;
          last       <= grant;
          resp_id    <= grant;
          if (sel_divisor == '0) begin
            // Zero divisor skips the divider entirely.
            resp_quotient  <= '1;
            resp_remainder <= sel_dividend;
            resp_divzero   <= 1'b1;
            resp_valid     <= 1'b1;
          end else begin
            cnt <= CNT_W'(WAIT_CYCLES - 1);
          end
        end
        WAIT: if (cnt == '0) begin
          resp_quotient  <= div_quotient;
          resp_remainder <= div_remainder;
          resp_divzero   <= 1'b0;
          resp_valid     <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        DONE: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef UDIV_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_count <= '0;
      stat1_count <= '0;
    end else if (resp_valid && resp_ready) begin
      if (!resp_id && stat0_count != 16'hFFFF) stat0_count <= stat0_count + 16'd1;
      if (resp_id && stat1_count != 16'hFFFF)  stat1_count <= stat1_count + 16'd1;
    end
  end
`endif

endmodule
